// File: rtl/n1_ifu_prefetch_if.sv
// Instruction-fetch memory port between the prefetch stage and instruction memory.
// Only one request is outstanding at a time. A request completes in the cycle
// where mem_valid and mem_ready are both high.
interface n1_ifu_prefetch_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/n1_ifu_prefetch.sv
// n1_ifu_prefetch: sequential instruction prefetch that feeds the decode IQ.
// It issues one word read at a time, strobes each returned word into the IQ,
// throttles fetch when the IQ is nearly full, and restarts at the target on a
// redirect. Data that was already in flight when the redirect arrived is dropped.
module n1_ifu_prefetch #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0,
  parameter bit          CATCH_MISALIGN = 1'b1,
  parameter int          IQ_PTR_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  input  logic [IQ_PTR_W-1:0] iq_rd_ptr_i,
  n1_ifu_prefetch_if.master   mem,
  output logic                instr_ready_o,
  output logic [31:0]         instr_rdata_o,
  output logic [IQ_PTR_W-1:0] iq_prefetch_ptr_o,
  output logic [31:0]         fetch_pc_o,
  output logic                misalign_o
);

  // DLVR is the strobe cycle after a completed read: the word goes to the IQ
  // and the space check decides between the next request and a stall.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_DLVR  = 3'd2;
  localparam logic [2:0] ST_STALL = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  // Fetch may continue while occupancy is below depth-2. That leaves one slot
  // for the word in flight, plus one slot kept free so that rd==wr always means empty.
  localparam logic [IQ_PTR_W-1:0] SPACE_LIM = IQ_PTR_W'((1 << IQ_PTR_W) - 2);

  logic [2:0]          state_r, state_n;
  logic [31:0]         fetch_pc_r, fetch_pc_n;
  logic                mem_valid_r, mem_valid_n;
  logic [31:0]         mem_addr_r, mem_addr_n;
  logic                instr_ready_r, instr_ready_n;
  logic [31:0]         instr_rdata_r, instr_rdata_n;
  logic                misalign_r, misalign_n;
  logic                pend_fault_r, pend_fault_n;
  logic [IQ_PTR_W-1:0] wr_ptr_r;

  logic                tgt_mis_s;
  logic [31:0]         tgt_pc_s;
  logic [IQ_PTR_W-1:0] occ_s;
  logic                space_s;
  logic                handshake_s;
  logic [31:0]         drain_pc_s;
  logic                drain_fault_s;
  logic                go_s;
  logic [31:0]         go_pc_s;
  logic                go_fault_s;

  assign iq_prefetch_ptr_o = wr_ptr_r + {{(IQ_PTR_W-1){1'b0}}, instr_ready_r};
  assign occ_s             = iq_prefetch_ptr_o - iq_rd_ptr_i;
  assign space_s           = (occ_s < SPACE_LIM);
  assign handshake_s       = mem_valid_r & mem.mem_ready;

  // A redirect that arrives during DRAIN replaces the pending target and its fault flag.
  assign drain_pc_s    = redirect_valid_i ? tgt_pc_s  : fetch_pc_r;
  assign drain_fault_s = redirect_valid_i ? tgt_mis_s : pend_fault_r;

  // Decode the redirect target: either flag a misaligned target or force word alignment.
  always_comb begin
    tgt_mis_s = 1'b0;
    tgt_pc_s  = redirect_pc_i;
    if (CATCH_MISALIGN) begin
      tgt_mis_s = (redirect_pc_i[1:0] != 2'b00);
      tgt_pc_s  = redirect_pc_i;
    end else begin
      tgt_mis_s = 1'b0;
      tgt_pc_s  = {redirect_pc_i[31:2], 2'b00};
    end
  end

  // Next-state logic. go_s launches a new request at go_pc_s, or enters FAULT instead.
  always_comb begin
    state_n       = state_r;
    fetch_pc_n    = fetch_pc_r;
    mem_valid_n   = mem_valid_r;
    mem_addr_n    = mem_addr_r;
    instr_ready_n = 1'b0;
    instr_rdata_n = instr_rdata_r;
    pend_fault_n  = pend_fault_r;
    misalign_n    = misalign_r;
    go_s          = 1'b0;
    go_pc_s       = fetch_pc_r;
    go_fault_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        go_s = 1'b1;
        if (redirect_valid_i) begin
          go_pc_s    = tgt_pc_s;
          go_fault_s = tgt_mis_s;
        end else begin
          go_pc_s    = fetch_pc_r;
          go_fault_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (redirect_valid_i) begin
          if (handshake_s) begin
            go_s       = 1'b1;
            go_pc_s    = tgt_pc_s;
            go_fault_s = tgt_mis_s;
          end else begin
            state_n      = ST_DRAIN;
            fetch_pc_n   = tgt_pc_s;
            pend_fault_n = tgt_mis_s;
          end
        end else if (handshake_s) begin
          state_n       = ST_DLVR;
          mem_valid_n   = 1'b0;
          instr_ready_n = 1'b1;
          instr_rdata_n = mem.mem_rdata;
          fetch_pc_n    = fetch_pc_r + 32'd4;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_DLVR, ST_STALL: begin
        if (redirect_valid_i) begin
          go_s       = 1'b1;
          go_pc_s    = tgt_pc_s;
          go_fault_s = tgt_mis_s;
        end else if (space_s) begin
          go_s    = 1'b1;
          go_pc_s = fetch_pc_r;
        end else begin
          state_n     = ST_STALL;
          mem_valid_n = 1'b0;
        end
      end
      ST_DRAIN: begin
        fetch_pc_n   = drain_pc_s;
        pend_fault_n = drain_fault_s;
        if (handshake_s) begin
          go_s       = 1'b1;
          go_pc_s    = drain_pc_s;
          go_fault_s = drain_fault_s;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_FAULT: begin
        if (redirect_valid_i) begin
          go_s       = 1'b1;
          go_pc_s    = tgt_pc_s;
          go_fault_s = tgt_mis_s;
        end else begin
          state_n = ST_FAULT;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        mem_valid_n = 1'b0;
      end
    endcase

    if (go_s) begin
      fetch_pc_n   = go_pc_s;
      pend_fault_n = 1'b0;
      misalign_n   = go_fault_s;
      if (go_fault_s) begin
        state_n     = ST_FAULT;
        mem_valid_n = 1'b0;
      end else begin
        state_n     = ST_REQ;
        mem_valid_n = 1'b1;
        mem_addr_n  = go_pc_s;
      end
    end else begin
      misalign_n = (state_n == ST_FAULT);
    end
  end

  // Register the state and all bus/IQ outputs. Reset drops any open request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      fetch_pc_r    <= PROGADDR_RESET;
      mem_valid_r   <= 1'b0;
      mem_addr_r    <= PROGADDR_RESET;
      instr_ready_r <= 1'b0;
      instr_rdata_r <= 32'h0;
      misalign_r    <= 1'b0;
      pend_fault_r  <= 1'b0;
    end else begin
      state_r       <= state_n;
      fetch_pc_r    <= fetch_pc_n;
      mem_valid_r   <= mem_valid_n;
      mem_addr_r    <= mem_addr_n;
      instr_ready_r <= instr_ready_n;
      instr_rdata_r <= instr_rdata_n;
      misalign_r    <= misalign_n;
      pend_fault_r  <= pend_fault_n;
    end
  end

  // The IQ write pointer advances in the cycle after each strobe, including strobes of stale words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {IQ_PTR_W{1'b0}};
    end else begin
      wr_ptr_r <= iq_prefetch_ptr_o;
    end
  end

  assign mem.mem_valid = mem_valid_r;
  assign mem.mem_addr  = mem_addr_r;
  assign instr_ready_o = instr_ready_r;
  assign instr_rdata_o = instr_rdata_r;
  assign fetch_pc_o    = fetch_pc_r;
  assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_n1_ifu_prefetch.sv
// Directed bench for n1_ifu_prefetch: a table-driven streaming/throttle run
// plus hand-written redirect, drain, misalign and reset sequences.
module tb_n1_ifu_prefetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [2:0]  iq_rd_ptr = 3'd0;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic [2:0]  iq_prefetch_ptr;
  logic [31:0] fetch_pc;
  logic        misalign;
  int          tests = 0;
  int          fails = 0;

  n1_ifu_prefetch_if mif();

  n1_ifu_prefetch #(
    .PROGADDR_RESET(32'h0),
    .CATCH_MISALIGN(1'b1),
    .IQ_PTR_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i(redirect_pc),
    .iq_rd_ptr_i(iq_rd_ptr),
    .mem(mif),
    .instr_ready_o(instr_ready),
    .instr_rdata_o(instr_rdata),
    .iq_prefetch_ptr_o(iq_prefetch_ptr),
    .fetch_pc_o(fetch_pc),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rd;
    logic [31:0] rdat;
    logic        ev;
    logic [31:0] ea;
    logic        eir;
    logic [31:0] erd;
    logic [2:0]  ep;
    logic [31:0] efpc;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [31:0] dw(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  function automatic vec_t mk(input logic [2:0] rd, input logic [31:0] rdat, input logic ev,
                              input logic [31:0] ea, input logic eir, input logic [31:0] erd,
                              input logic [2:0] ep, input logic [31:0] efpc);
    vec_t v;
    v.rd = rd; v.rdat = rdat; v.ev = ev; v.ea = ea;
    v.eir = eir; v.erd = erd; v.ep = ep; v.efpc = efpc;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic apply(input logic rv, input logic [31:0] rpc, input logic [2:0] rd,
                       input logic rdy, input logic [31:0] rdat);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    iq_rd_ptr      = rd;
    mif.mem_ready  = rdy;
    mif.mem_rdata  = rdat;
    #1;
  endtask

  // Pulse reset; release it just after a rising edge so the next apply sees IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    iq_rd_ptr      = 3'd0;
    mif.mem_ready  = 1'b0;
    mif.mem_rdata  = 32'h0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;

    // Streaming with memory always ready. The IQ fills, then fetch resumes as rd moves, and wr_ptr wraps.
    tbl[0]  = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b0, 32'h0,      3'd0, 32'h0);
    tbl[1]  = mk(3'd0, dw(32'd0),  1'b1, 32'd0,  1'b0, 32'h0,      3'd0, 32'd0);
    tbl[2]  = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd0),  3'd1, 32'd4);
    tbl[3]  = mk(3'd0, dw(32'd4),  1'b1, 32'd4,  1'b0, dw(32'd0),  3'd1, 32'd4);
    tbl[4]  = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd4),  3'd2, 32'd8);
    tbl[5]  = mk(3'd0, dw(32'd8),  1'b1, 32'd8,  1'b0, dw(32'd4),  3'd2, 32'd8);
    tbl[6]  = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd8),  3'd3, 32'd12);
    tbl[7]  = mk(3'd0, dw(32'd12), 1'b1, 32'd12, 1'b0, dw(32'd8),  3'd3, 32'd12);
    tbl[8]  = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd12), 3'd4, 32'd16);
    tbl[9]  = mk(3'd0, dw(32'd16), 1'b1, 32'd16, 1'b0, dw(32'd12), 3'd4, 32'd16);
    tbl[10] = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd16), 3'd5, 32'd20);
    tbl[11] = mk(3'd0, dw(32'd20), 1'b1, 32'd20, 1'b0, dw(32'd16), 3'd5, 32'd20);
    tbl[12] = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd20), 3'd6, 32'd24);
    tbl[13] = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd20), 3'd6, 32'd24);
    tbl[14] = mk(3'd0, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd20), 3'd6, 32'd24);
    tbl[15] = mk(3'd2, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd20), 3'd6, 32'd24);
    tbl[16] = mk(3'd2, dw(32'd24), 1'b1, 32'd24, 1'b0, dw(32'd20), 3'd6, 32'd24);
    tbl[17] = mk(3'd2, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd24), 3'd7, 32'd28);
    tbl[18] = mk(3'd2, dw(32'd28), 1'b1, 32'd28, 1'b0, dw(32'd24), 3'd7, 32'd28);
    tbl[19] = mk(3'd2, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd28), 3'd0, 32'd32);
    tbl[20] = mk(3'd2, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd28), 3'd0, 32'd32);
    tbl[21] = mk(3'd4, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd28), 3'd0, 32'd32);
    tbl[22] = mk(3'd4, dw(32'd32), 1'b1, 32'd32, 1'b0, dw(32'd28), 3'd0, 32'd32);
    tbl[23] = mk(3'd4, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd32), 3'd1, 32'd36);
    tbl[24] = mk(3'd4, dw(32'd36), 1'b1, 32'd36, 1'b0, dw(32'd32), 3'd1, 32'd36);
    tbl[25] = mk(3'd4, 32'h0,      1'b0, 32'h0,  1'b1, dw(32'd36), 3'd2, 32'd40);
    tbl[26] = mk(3'd4, 32'h0,      1'b0, 32'h0,  1'b0, dw(32'd36), 3'd2, 32'd40);

    // Reset values while reset is held.
    @(negedge clk);
    #1;
    chk1 ("rst mem_valid",   mif.mem_valid,   1'b0);
    chk32("rst mem_addr",    mif.mem_addr,    32'h0);
    chk1 ("rst instr_ready", instr_ready,     1'b0);
    chk32("rst instr_rdata", instr_rdata,     32'h0);
    chk3 ("rst ptr",         iq_prefetch_ptr, 3'd0);
    chk32("rst fetch_pc",    fetch_pc,        32'h0);
    chk1 ("rst misalign",    misalign,        1'b0);

    // Table-driven streaming run.
    do_reset();
    for (int i = 0; i < 27; i++) begin
      apply(1'b0, 32'h0, tbl[i].rd, 1'b1, tbl[i].rdat);
      chk1 ($sformatf("tbl%0d mem_valid", i), mif.mem_valid, tbl[i].ev);
      if (tbl[i].ev) chk32($sformatf("tbl%0d mem_addr", i), mif.mem_addr, tbl[i].ea);
      chk1 ($sformatf("tbl%0d instr_ready", i), instr_ready, tbl[i].eir);
      chk32($sformatf("tbl%0d instr_rdata", i), instr_rdata, tbl[i].erd);
      chk3 ($sformatf("tbl%0d ptr", i), iq_prefetch_ptr, tbl[i].ep);
      chk32($sformatf("tbl%0d fetch_pc", i), fetch_pc, tbl[i].efpc);
      chk1 ($sformatf("tbl%0d misalign", i), misalign, 1'b0);
    end

    // Redirect while a request is stalled: drain the old request, discard its data, refetch at 0x100.
    do_reset();
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    apply(1'b1, 32'h100, 3'd0, 1'b0, 32'h0);
    chk1 ("drn c1 valid", mif.mem_valid, 1'b1);
    chk32("drn c1 addr",  mif.mem_addr,  32'h0);
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk1 ("drn c2 valid", mif.mem_valid, 1'b1);
    chk32("drn c2 addr",  mif.mem_addr,  32'h0);
    chk32("drn c2 fetch_pc", fetch_pc, 32'h100);
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk32("drn c3 addr",  mif.mem_addr,  32'h0);
    apply(1'b0, 32'h0, 3'd0, 1'b1, 32'hDEAD_BEEF);
    chk32("drn c4 addr",  mif.mem_addr,  32'h0);
    apply(1'b0, 32'h0, 3'd0, 1'b1, dw(32'h100));
    chk1 ("drn c5 no strobe", instr_ready, 1'b0);
    chk1 ("drn c5 valid", mif.mem_valid, 1'b1);
    chk32("drn c5 addr",  mif.mem_addr,  32'h100);
    chk3 ("drn c5 ptr",   iq_prefetch_ptr, 3'd0);
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk1 ("drn c6 strobe", instr_ready, 1'b1);
    chk32("drn c6 rdata",  instr_rdata, dw(32'h100));
    chk3 ("drn c6 ptr",    iq_prefetch_ptr, 3'd1);
    chk32("drn c6 fetch_pc", fetch_pc, 32'h104);
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk1 ("rstmid before", mif.mem_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1 ("rstmid valid",    mif.mem_valid, 1'b0);
    chk32("rstmid fetch_pc", fetch_pc,      32'h0);
    chk3 ("rstmid ptr",      iq_prefetch_ptr, 3'd0);

    // Redirect with a concurrent handshake, then a redirect on the strobe cycle with wr_ptr=3.
    do_reset();
    for (int k = 0; k < 7; k++) apply(1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    apply(1'b1, 32'h300, 3'd0, 1'b1, 32'hBAD0_0007);
    chk3 ("rdh c7 ptr",  iq_prefetch_ptr, 3'd3);
    chk32("rdh c7 addr", mif.mem_addr, 32'd12);
    apply(1'b0, 32'h0, 3'd0, 1'b1, dw(32'h300));
    chk1 ("rdh c8 dropped", instr_ready, 1'b0);
    chk32("rdh c8 addr", mif.mem_addr, 32'h300);
    chk3 ("rdh c8 ptr",  iq_prefetch_ptr, 3'd3);
    apply(1'b1, 32'h400, 3'd0, 1'b1, 32'h0);
    chk1 ("rdh c9 strobe", instr_ready, 1'b1);
    chk32("rdh c9 rdata",  instr_rdata, dw(32'h300));
    chk3 ("rdh c9 ptr",    iq_prefetch_ptr, 3'd4);
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk1 ("rdh c10 valid", mif.mem_valid, 1'b1);
    chk32("rdh c10 addr",  mif.mem_addr, 32'h400);
    chk3 ("rdh c10 ptr",   iq_prefetch_ptr, 3'd4);
    chk32("rdh c10 fetch_pc", fetch_pc, 32'h400);

    // Misaligned redirect halts fetch until a valid redirect arrives.
    do_reset();
    apply(1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    apply(1'b1, 32'h102, 3'd0, 1'b1, 32'hBAD1_0000);
    chk1 ("mis c1 misalign", misalign, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
      chk1 ($sformatf("mis hold%0d misalign", k), misalign, 1'b1);
      chk1 ($sformatf("mis hold%0d valid", k), mif.mem_valid, 1'b0);
      chk1 ($sformatf("mis hold%0d strobe", k), instr_ready, 1'b0);
    end
    chk32("mis fetch_pc", fetch_pc, 32'h102);
    apply(1'b1, 32'h200, 3'd0, 1'b1, 32'h0);
    chk1 ("mis redir misalign", misalign, 1'b1);
    apply(1'b0, 32'h0, 3'd0, 1'b1, dw(32'h200));
    chk1 ("mis clr misalign", misalign, 1'b0);
    chk1 ("mis clr valid", mif.mem_valid, 1'b1);
    chk32("mis clr addr",  mif.mem_addr, 32'h200);
    apply(1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    chk32("mis clr rdata", instr_rdata, dw(32'h200));
    chk3 ("mis clr ptr",   iq_prefetch_ptr, 3'd1);

    // Second redirect during DRAIN replaces the target; a misaligned target faults only after the drain.
    do_reset();
    apply(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    apply(1'b1, 32'h104, 3'd0, 1'b0, 32'h0);
    apply(1'b1, 32'h102, 3'd0, 1'b0, 32'h0);
    chk32("rep c2 fetch_pc", fetch_pc, 32'h104);
    chk1 ("rep c2 valid", mif.mem_valid, 1'b1);
    apply(1'b0, 32'h0, 3'd0, 1'b1, 32'hBAD2_0000);
    chk1 ("rep c3 misalign", misalign, 1'b0);
    chk32("rep c3 addr", mif.mem_addr, 32'h0);
    chk32("rep c3 fetch_pc", fetch_pc, 32'h102);
    apply(1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    chk1 ("rep c4 misalign", misalign, 1'b1);
    chk1 ("rep c4 valid", mif.mem_valid, 1'b0);
    chk1 ("rep c4 strobe", instr_ready, 1'b0);
    chk3 ("rep c4 ptr", iq_prefetch_ptr, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
